// File: rtl/dram_host_sequencer_if.sv
// Host-side request/response bundle of the DRAM host sequencer.
// The requester uses the master modport; the sequencer uses the slave modport.
interface dram_host_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata
  );
endinterface

// File: rtl/dram_host_sequencer.sv
// Converts a valid/ready single-word request stream into the SDRAM controller's fixed-timing host
// interface. Define DRAM_SEQ_SKID_EN to add a one-entry pending buffer accepted during ISSUE/WAIT.
module dram_host_sequencer #(
  parameter int INIT_WAIT  = 20100,
  parameter int WRITE_WAIT = 8,
  parameter int READ_WAIT  = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  dram_host_sequencer_if.slave        host,
  output logic                        init_done,
  output logic [23:0]                 haddr,
  output logic [15:0]                 data_input,
  input  logic [15:0]                 data_output,
  output logic                        rd_enable,
  output logic                        wr_enable
);

  localparam int CNT_MAX_IW = (INIT_WAIT > WRITE_WAIT) ? INIT_WAIT : WRITE_WAIT;
  localparam int CNT_MAX    = (CNT_MAX_IW > READ_WAIT) ? CNT_MAX_IW : READ_WAIT;
  localparam int CNT_W      = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] INIT_LD  = CNT_W'(INIT_WAIT - 1);
  localparam logic [CNT_W-1:0] WRITE_LD = CNT_W'(WRITE_WAIT - 1);
  localparam logic [CNT_W-1:0] READ_LD  = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               op_we_q;
  logic               init_done_q;
  logic               req_ready_q;
  logic               rd_en_q;
  logic               wr_en_q;
  logic               rsp_valid_q;
  logic [23:0]        haddr_q;
  logic [15:0]        wdata_q;
  logic [15:0]        rdata_q;
  logic               accept;

`ifdef DRAM_SEQ_SKID_EN
  logic               pend_valid_q;
  logic               pend_we_q;
  logic [23:0]        pend_addr_q;
  logic [15:0]        pend_wdata_q;
`endif

  assign accept = host.req_valid && req_ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      cnt_q        <= INIT_LD;
      op_we_q      <= 1'b0;
      init_done_q  <= 1'b0;
      req_ready_q  <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      haddr_q      <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
`ifdef DRAM_SEQ_SKID_EN
      pend_valid_q <= 1'b0;
`endif
    end else begin
      // Command and response strobes are single-cycle unless re-asserted below.
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;

      case (state_q)
        S_INIT: begin
          if (cnt_q == CNT_ZERO) begin
            state_q     <= S_IDLE;
            init_done_q <= 1'b1;
            req_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        S_IDLE: begin
`ifdef DRAM_SEQ_SKID_EN
          if (pend_valid_q) begin
            haddr_q      <= pend_addr_q;
            wdata_q      <= pend_wdata_q;
            op_we_q      <= pend_we_q;
            wr_en_q      <= pend_we_q;
            rd_en_q      <= !pend_we_q;
            pend_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_ISSUE;
          end else if (accept) begin
            haddr_q <= host.req_addr;
            wdata_q <= host.req_wdata;
            op_we_q <= host.req_we;
            wr_en_q <= host.req_we;
            rd_en_q <= !host.req_we;
            state_q <= S_ISSUE;
          end
`else
          if (accept) begin
            haddr_q     <= host.req_addr;
            wdata_q     <= host.req_wdata;
            op_we_q     <= host.req_we;
            wr_en_q     <= host.req_we;
            rd_en_q     <= !host.req_we;
            req_ready_q <= 1'b0;
            state_q     <= S_ISSUE;
          end
`endif
        end

        S_ISSUE: begin
          cnt_q   <= op_we_q ? WRITE_LD : READ_LD;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (cnt_q == CNT_ZERO) begin
            state_q <= S_IDLE;
`ifndef DRAM_SEQ_SKID_EN
            req_ready_q <= 1'b1;
`endif
            // Read data is only guaranteed valid at this edge; capture it here.
            if (!op_we_q) begin
              rdata_q     <= data_output;
              rsp_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        default: begin
          state_q <= S_INIT;
          cnt_q   <= INIT_LD;
        end
      endcase

`ifdef DRAM_SEQ_SKID_EN
      // While a command is in flight, a new request parks in the pending slot.
      if (accept && (state_q != S_IDLE)) begin
        pend_valid_q <= 1'b1;
        pend_we_q    <= host.req_we;
        pend_addr_q  <= host.req_addr;
        pend_wdata_q <= host.req_wdata;
        req_ready_q  <= 1'b0;
      end
`endif
    end
  end

  assign host.req_ready = req_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_rdata = rdata_q;
  assign init_done      = init_done_q;
  assign haddr          = haddr_q;
  assign data_input     = wdata_q;
  assign rd_enable      = rd_en_q;
  assign wr_enable      = wr_en_q;

endmodule
